sync_fifo_flags: RTL and testbench

SYNC_FIFO_FLAGS -- requirements
Module: sync_fifo_flags

---
 rtl/sync_fifo_flags.sv | 154 +++++++++++++++
 tb/tb_sync_fifo_flags.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock FIFO with registered occupancy count,
// full/empty and almost-full/almost-empty flags, and sticky overflow/underflow.
// Read mode is selected at build time by the macro SYNC_FIFO_FWFT_EN:
//   undefined -> registered read data, valid the cycle after an accepted read
//   defined   -> first-word fall-through, rdata presents the head word
module sync_fifo_flags #(
    parameter int DSIZE     = 8,
    parameter int ASIZE     = 4,
    parameter int AFULL_TH  = (1 << ASIZE) - 2,
    parameter int AEMPTY_TH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DSIZE-1:0] wdata,
    input  logic             winc,
    output logic             wfull,
    output logic             walmost_full,
    input  logic             rinc,
    output logic [DSIZE-1:0] rdata,
    output logic             rempty,
    output logic             ralmost_empty,
    output logic [ASIZE:0]   count,
    output logic             overflow,
    output logic             underflow
);

    localparam int unsigned DW    = DSIZE;
    localparam int unsigned AW    = ASIZE;
    localparam int unsigned PW    = ASIZE + 1;
    localparam int unsigned DEPTH = 1 << ASIZE;

    localparam logic [PW-1:0] FULL_LVL   = PW'(DEPTH);
    localparam logic [PW-1:0] AFULL_LVL  = PW'(AFULL_TH);
    localparam logic [PW-1:0] AEMPTY_LVL = PW'(AEMPTY_TH);

    // Reject threshold sets that make the almost flags meaningless.
    if (AEMPTY_TH >= AFULL_TH || AFULL_TH > (1 << ASIZE) || AFULL_TH < 1) begin : g_bad_thresholds
        $error("sync_fifo_flags: illegal AFULL_TH/AEMPTY_TH for this ASIZE");
    end

    logic [DW-1:0] mem [DEPTH];

    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [PW-1:0] wptr_next;
    logic [PW-1:0] rptr_next;
    logic [PW-1:0] count_next;
    logic [AW-1:0] waddr;
    logic          wr_en;
    logic          rd_en;

    // Acceptance is decided on the flags as they stand before the edge.
    always_comb begin
        wr_en = winc & ~wfull;
        rd_en = rinc & ~rempty;
        waddr = wptr[AW-1:0];
    end

    // Next pointers and occupancy; pointers carry one wrap bit.
    always_comb begin
        wptr_next  = wptr + PW'(wr_en);
        rptr_next  = rptr + PW'(rd_en);
        count_next = count;
        case ({wr_en, rd_en})
            2'b10:   count_next = count + PW'(1);
            2'b01:   count_next = count - PW'(1);
            default: count_next = count;
        endcase
    end

    // Pointer, occupancy and flag registers; flags track post-edge occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr          <= '0;
            rptr          <= '0;
            count         <= '0;
            wfull         <= 1'b0;
            walmost_full  <= 1'b0;
            rempty        <= 1'b1;
            ralmost_empty <= 1'b1;
        end else begin
            wptr          <= wptr_next;
            rptr          <= rptr_next;
            count         <= count_next;
            wfull         <= (count_next == FULL_LVL);
            walmost_full  <= (count_next >= AFULL_LVL);
            rempty        <= (count_next == '0);
            ralmost_empty <= (count_next <= AEMPTY_LVL);
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= overflow  | (winc & wfull);
            underflow <= underflow | (rinc & rempty);
        end
    end

    // Storage array; not reset, and a write coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            mem[waddr] <= wdata;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN

    logic [AW-1:0] head_addr;
    logic [DW-1:0] head_word;

    // Head word after this edge; bypass the array when the write lands at the head.
    always_comb begin
        head_addr = rptr_next[AW-1:0];
        if (wr_en && (wptr == rptr_next)) begin
            head_word = wdata;
        end else begin
            head_word = mem[head_addr];
        end
    end

    // Present the head word; hold the last value while the FIFO goes empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (count_next != '0) begin
            rdata <= head_word;
        end
    end

`else

    logic [AW-1:0] raddr;

    // Read address is the current head.
    always_comb begin
        raddr = rptr[AW-1:0];
    end

    // Registered read data, loaded only on an accepted read.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (rd_en) begin
            rdata <= mem[raddr];
        end
    end

`endif

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed testbench for sync_fifo_flags (default parameters, either read mode).
module tb_sync_fifo_flags;

    logic       clk;
    logic       rst;
    logic [7:0] wdata;
    logic       winc;
    logic       wfull;
    logic       walmost_full;
    logic       rinc;
    logic [7:0] rdata;
    logic       rempty;
    logic       ralmost_empty;
    logic [4:0] count;
    logic       overflow;
    logic       underflow;

    int checks   = 0;
    int failures = 0;

`ifdef SYNC_FIFO_FWFT_EN
    localparam int HEAD_OFS = 1;
`else
    localparam int HEAD_OFS = 0;
`endif

    sync_fifo_flags dut (
        .clk           (clk),
        .rst           (rst),
        .wdata         (wdata),
        .winc          (winc),
        .wfull         (wfull),
        .walmost_full  (walmost_full),
        .rinc          (rinc),
        .rdata         (rdata),
        .rempty        (rempty),
        .ralmost_empty (ralmost_empty),
        .count         (count),
        .overflow      (overflow),
        .underflow     (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if it does not match.
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One clock with the given requests, then idle the request lines.
    task automatic cycle(input bit w, input int d, input bit r);
        winc  = w;
        wdata = 8'(d);
        rinc  = r;
        tick();
        winc  = 1'b0;
        rinc  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Read one word and compare it, accounting for the read-mode timing.
    task automatic read_check(input string tag, input int exp);
`ifdef SYNC_FIFO_FWFT_EN
        check_val(tag, 32'(rdata), 32'(exp));
        cycle(1'b0, 0, 1'b1);
`else
        cycle(1'b0, 0, 1'b1);
        check_val(tag, 32'(rdata), 32'(exp));
`endif
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, "_count"},  32'(count), 0);
        check_val({tag, "_rempty"}, 32'(rempty), 1);
        check_val({tag, "_raempty"}, 32'(ralmost_empty), 1);
        check_val({tag, "_wfull"},  32'(wfull), 0);
        check_val({tag, "_wafull"}, 32'(walmost_full), 0);
        check_val({tag, "_ovf"},    32'(overflow), 0);
        check_val({tag, "_unf"},    32'(underflow), 0);
        check_val({tag, "_rdata"},  32'(rdata), 0);
    endtask

    // Hard stop if the sequence ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst   = 1'b1;
        winc  = 1'b0;
        rinc  = 1'b0;
        wdata = '0;

        // Reset state
        do_reset();
        check_reset_state("rst");

        // Three consecutive writes, then read back
        cycle(1'b1, 'h11, 1'b0);
        check_val("w1_rempty", 32'(rempty), 0);
        check_val("w1_count", 32'(count), 1);
        cycle(1'b1, 'h22, 1'b0);
        cycle(1'b1, 'h33, 1'b0);
        check_val("w3_count", 32'(count), 3);
        check_val("w3_rempty", 32'(rempty), 0);
        check_val("w3_raempty", 32'(ralmost_empty), 0);
        read_check("rd_11", 'h11);
        check_val("r1_raempty", 32'(ralmost_empty), 1);
        read_check("rd_22", 'h22);
        read_check("rd_33", 'h33);
        check_val("r3_count", 32'(count), 0);
        check_val("r3_rempty", 32'(rempty), 1);

        // Fill to full, overflow attempt, drain in order
        do_reset();
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, i, 1'b0);
            check_val($sformatf("fill%0d_count", i), 32'(count), 32'(i + 1));
            check_val($sformatf("fill%0d_wafull", i), 32'(walmost_full), 32'((i + 1) >= 14));
            check_val($sformatf("fill%0d_wfull", i), 32'(wfull), 32'((i + 1) == 16));
        end
        cycle(1'b1, 'hAA, 1'b0);
        check_val("ovf_flag", 32'(overflow), 1);
        check_val("ovf_count", 32'(count), 16);
        check_val("ovf_wfull", 32'(wfull), 1);
        for (int i = 0; i < 16; i++) begin
            read_check($sformatf("drain%0d", i), i);
        end
        check_val("drain_count", 32'(count), 0);
        check_val("drain_rempty", 32'(rempty), 1);
        check_val("drain_wfull", 32'(wfull), 0);

        // Underflow on empty; both sticky flags persist
        cycle(1'b0, 0, 1'b1);
        check_val("unf_flag", 32'(underflow), 1);
        check_val("unf_count", 32'(count), 0);
        check_val("unf_rdata", 32'(rdata), 'h0F);
        cycle(1'b0, 0, 1'b0);
        cycle(1'b0, 0, 1'b0);
        check_val("sticky_ovf", 32'(overflow), 1);
        check_val("sticky_unf", 32'(underflow), 1);
        do_reset();
        check_val("clr_ovf", 32'(overflow), 0);
        check_val("clr_unf", 32'(underflow), 0);

        // Occupancy 8 with simultaneous read/write long enough to wrap the pointers
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, i, 1'b0);
        end
        check_val("half_count", 32'(count), 8);
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, 8 + i, 1'b1);
            check_val($sformatf("rw%0d_count", i), 32'(count), 8);
            check_val($sformatf("rw%0d_rdata", i), 32'(rdata), 32'(i + HEAD_OFS));
        end
        for (int i = 0; i < 8; i++) begin
            read_check($sformatf("rwdrain%0d", i), 40 + i);
        end
        check_val("rwdrain_rempty", 32'(rempty), 1);
        check_val("rw_ovf", 32'(overflow), 0);
        check_val("rw_unf", 32'(underflow), 0);

        // Full FIFO with both requests: read wins, write rejected
        do_reset();
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 'h30 + i, 1'b0);
        end
        cycle(1'b1, 'hEE, 1'b1);
        check_val("fb_ovf", 32'(overflow), 1);
        check_val("fb_count", 32'(count), 15);
        check_val("fb_wfull", 32'(wfull), 0);
        check_val("fb_rdata", 32'(rdata), 32'('h30 + HEAD_OFS));
        for (int i = 1; i < 16; i++) begin
            read_check($sformatf("fbdrain%0d", i), 'h30 + i);
        end
        check_val("fbdrain_rempty", 32'(rempty), 1);

        // Empty FIFO with both requests: write wins, read rejected
        cycle(1'b1, 'h77, 1'b1);
        check_val("eb_unf", 32'(underflow), 1);
        check_val("eb_count", 32'(count), 1);
        check_val("eb_rempty", 32'(rempty), 0);
        check_val("eb_rdata", 32'(rdata), 32'(HEAD_OFS != 0 ? 'h77 : 'h3F));
        read_check("eb_rd", 'h77);

        // Single word round trip in the selected read mode
        do_reset();
        cycle(1'b1, 'h5A, 1'b0);
        check_val("5a_rempty", 32'(rempty), 0);
        read_check("5a_rd", 'h5A);

        // Reset mid-stream takes priority over requests and discards contents
        cycle(1'b0, 0, 1'b1);
        cycle(1'b1, 'hC1, 1'b0);
        cycle(1'b1, 'hC2, 1'b0);
        cycle(1'b1, 'hC3, 1'b0);
        check_val("mid_count", 32'(count), 3);
        rst = 1'b1;
        cycle(1'b1, 'hC4, 1'b1);
        rst = 1'b0;
        check_reset_state("mid");
        cycle(1'b0, 0, 1'b1);
        check_val("mid_unf", 32'(underflow), 1);
        check_val("mid_post_count", 32'(count), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
